// File: rtl/cal_field_counter.sv
// Rollover counter for one calendar/clock field with carry chaining,
// hold-to-repeat set buttons, clamped load and registered BCD digits.
module cal_field_counter #(
   parameter int WIDTH      = 7,
   parameter int MIN_VAL    = 1,
   parameter int MAX_VAL    = 99,
   parameter int RESET_VAL  = 1,
   parameter int HOLD_TICKS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             carry_in,
   input  logic             btn_up,
   input  logic             btn_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value,
   output logic             carry_out,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones
);

   localparam int HW = $clog2(HOLD_TICKS + 1);

   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] TEN   = WIDTH'(10);
   localparam logic [HW-1:0]    HOLD  = HW'(HOLD_TICKS);
   localparam logic [HW-1:0]    ONE   = HW'(1);

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      REPEAT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              dir;
   logic              dir_nxt;
   logic [HW-1:0]     hold_cnt;
   logic [HW-1:0]     hold_nxt;
   logic              step;
   logic              pressed;
   logic [WIDTH-1:0]  inc_val;
   logic [WIDTH-1:0]  dec_val;
   logic [WIDTH-1:0]  clamp_val;
   logic [WIDTH-1:0]  val_nxt;
   logic              carry_nxt;

   // Both buttons high is treated as released.
   assign pressed = btn_up ^ btn_dn;

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      hold_nxt  = hold_cnt;
      step      = 1'b0;
      if (load) begin
         state_nxt = IDLE;
         hold_nxt  = '0;
      end else if (tick) begin
         unique case (state)
            IDLE: begin
               if (pressed) begin
                  dir_nxt   = btn_up;
                  step      = 1'b1;
                  hold_nxt  = ONE;
                  state_nxt = PRESSED;
               end
            end
            PRESSED: begin
               if (!pressed) begin
                  state_nxt = IDLE;
                  hold_nxt  = '0;
               end else if (btn_up != dir) begin
                  dir_nxt  = btn_up;
                  step     = 1'b1;
                  hold_nxt = ONE;
               end else if (hold_cnt >= HOLD) begin
                  step      = 1'b1;
                  state_nxt = REPEAT;
               end else begin
                  hold_nxt = hold_cnt + ONE;
               end
            end
            REPEAT: begin
               if (!pressed) begin
                  state_nxt = IDLE;
                  hold_nxt  = '0;
               end else if (btn_up != dir) begin
                  dir_nxt   = btn_up;
                  step      = 1'b1;
                  hold_nxt  = ONE;
                  state_nxt = PRESSED;
               end else begin
                  step = 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               hold_nxt  = '0;
            end
         endcase
      end
   end

   assign inc_val = (value == MAX_V) ? MIN_V : value + WIDTH'(1);
   assign dec_val = (value == MIN_V) ? MAX_V : value - WIDTH'(1);

   always_comb begin
      clamp_val = load_val;
      if (load_val < MIN_V)
         clamp_val = MIN_V;
      else if (load_val > MAX_V)
         clamp_val = MAX_V;
   end

   // carry_in wins over a simultaneous button step; both never add twice.
   always_comb begin
      val_nxt   = value;
      carry_nxt = 1'b0;
      if (load) begin
         val_nxt = clamp_val;
      end else if (tick && carry_in) begin
         val_nxt   = inc_val;
         carry_nxt = (value == MAX_V);
      end else if (tick && step) begin
         val_nxt = dir_nxt ? inc_val : dec_val;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         dir      <= 1'b1;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         dir      <= dir_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value     <= RST_V;
         carry_out <= 1'b0;
         bcd_tens  <= 4'(RESET_VAL / 10);
         bcd_ones  <= 4'(RESET_VAL % 10);
      end else begin
         value     <= val_nxt;
         carry_out <= carry_nxt;
         bcd_tens  <= 4'(val_nxt / TEN);
         bcd_ones  <= 4'(val_nxt % TEN);
      end
   end

endmodule
